// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Optional `UART_ARB_PRIORITY_EN makes requester 0 always win when it requests.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 87,
    parameter int GUARD        = 2
) (
    input  logic                   clkTx,
    input  logic                   resetreg,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   reqData,
    output logic [NUM_REQ-1:0]     grant,
    output logic [7:0]             txData,
    output logic                   txStart,
    output logic                   busy
);

    localparam int FRAME = 10 * CLKS_PER_BIT + GUARD;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0] FRAME_LAST = 16'(FRAME - 1);
    localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);

    generate
        if (FRAME > 65535) begin : g_frame_too_long
            $error("uart_tx_arbiter: FRAME exceeds the 16-bit frame counter");
        end
        if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
            $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         count_q, count_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;

    logic                found;
    logic [IDX_W-1:0]    winner;
    logic [IDX_W-1:0]    cand;
    logic [7:0]          sel_data;

    // Winner search starts just after the last granted index and wraps.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
`ifdef UART_ARB_PRIORITY_EN
        if (req[0]) begin
            found  = 1'b1;
            winner = '0;
        end
        for (int o = 1; o < NUM_REQ; o++) begin
            cand = IDX_W'(((int'(last_q) + o - 1) % (NUM_REQ - 1)) + 1);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
`else
        for (int o = 1; o <= NUM_REQ; o++) begin
            cand = IDX_W'((int'(last_q) + o) % NUM_REQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
`endif
        sel_data = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IDX_W'(i)) begin
                sel_data = reqData[i*8 +: 8];
            end
        end
    end

    // txStart and grant are registered, so they pulse in the cycle after ISSUE.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        last_d     = last_q;
        win_d      = win_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        grant_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    win_d     = winner;
                    tx_data_d = sel_data;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tx_start_d = 1'b1;
                for (int i = 0; i < NUM_REQ; i++) begin
                    grant_d[i] = (win_q == IDX_W'(i));
                end
                count_d = 16'd0;
`ifdef UART_ARB_PRIORITY_EN
                if (win_q != '0) begin
                    last_d = win_q;
                end
`else
                last_d = win_q;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                count_d = count_q + 16'd1;
                if (count_q == FRAME_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clkTx or posedge resetreg) begin
        if (resetreg) begin
            state_q    <= S_IDLE;
            count_q    <= 16'd0;
            last_q     <= LAST_RESET;
            win_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            grant_q    <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            last_q     <= last_d;
            win_q      <= win_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            grant_q    <= grant_d;
        end
    end

    assign grant   = grant_q;
    assign txData  = tx_data_q;
    assign txStart = tx_start_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants are queued by the stimulus
// and checked by an independent monitor whenever the DUT pulses grant/txStart.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int SPACING     = 874;
    localparam int BUSY_CYCLES = 873;
    localparam int WAIT_LIMIT  = 3000;

    logic        clkTx = 1'b0;
    logic        resetreg;
    logic [3:0]  req;
    logic [31:0] reqData;
    logic [3:0]  grant;
    logic [7:0]  txData;
    logic        txStart;
    logic        busy;

    typedef struct {
        logic [3:0] grant;
        logic [7:0] data;
    } exp_t;

    exp_t expQ[$];
    int   nCompared   = 0;
    int   nMismatched = 0;
    int   cyc         = 0;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .CLKS_PER_BIT(87),
        .GUARD(2)
    ) dut (
        .clkTx(clkTx),
        .resetreg(resetreg),
        .req(req),
        .reqData(reqData),
        .grant(grant),
        .txData(txData),
        .txStart(txStart),
        .busy(busy)
    );

    always #5 clkTx = ~clkTx;

    always @(posedge clkTx) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL %s: timed out after %0d cycles", name, WAIT_LIMIT);
    endtask

    task automatic applyStimulus(input logic [3:0] r);
        req = r;
    endtask

    task automatic pushExp(input int idx);
        exp_t e;
        e.grant = 4'b0001 << idx;
        e.data  = reqData[idx*8 +: 8];
        expQ.push_back(e);
    endtask

    task automatic waitGrant(output int idx, output int waited);
        idx    = -1;
        waited = 0;
        while (waited < WAIT_LIMIT) begin
            @(negedge clkTx);
            waited++;
            if (grant !== 4'b0000) break;
        end
        if (grant === 4'b0000) begin
            timeoutFail("waitGrant");
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] === 1'b1) idx = i;
            end
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < WAIT_LIMIT) begin
            @(negedge clkTx);
            n++;
        end
        if (busy !== 1'b0) timeoutFail("waitIdle");
    endtask

    task automatic doReset();
        resetreg = 1'b1;
        req      = 4'b0000;
        repeat (3) @(negedge clkTx);
        resetreg = 1'b0;
        @(negedge clkTx);
    endtask

    // Monitor: every grant/txStart pulse must match the next queued expectation.
    always @(negedge clkTx) begin
        if (resetreg === 1'b0 && (grant !== 4'b0000 || txStart !== 1'b0)) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected grant", {27'b0, txStart, grant}, 32'h0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("grant", {28'b0, grant}, {28'b0, e.grant});
                checkOutput("txData at grant", {24'b0, txData}, {24'b0, e.data});
                checkOutput("txStart with grant", {31'b0, txStart}, 32'h1);
            end
        end
    end

    initial begin
        int g, w, n, t, prevT, t1, t2;
        int seq6[6];
`ifdef UART_ARB_PRIORITY_EN
        seq6 = '{0, 0, 0, 1, 2, 1};
`else
        seq6 = '{0, 1, 2, 1, 2, 1};
`endif
        resetreg = 1'b1;
        req      = 4'b0000;
        reqData  = 32'h0;
        repeat (2) @(negedge clkTx);
        checkOutput("reset grant", {28'b0, grant}, 32'h0);
        checkOutput("reset txStart", {31'b0, txStart}, 32'h0);
        checkOutput("reset txData", {24'b0, txData}, 32'h0);
        checkOutput("reset busy", {31'b0, busy}, 32'h0);
        resetreg = 1'b0;
        @(negedge clkTx);

        // Single request, latency and busy length.
        reqData[7:0] = 8'hA5;
        pushExp(0);
        applyStimulus(4'b0001);
        @(negedge clkTx);
        checkOutput("issue busy", {31'b0, busy}, 32'h1);
        checkOutput("issue txStart", {31'b0, txStart}, 32'h0);
        checkOutput("issue txData", {24'b0, txData}, 32'hA5);
        waitGrant(g, w);
        checkOutput("grant latency", w, 1);
        applyStimulus(4'b0000);
        n = 2;
        do begin
            @(negedge clkTx);
            if (busy === 1'b1) n++;
        end while (busy === 1'b1 && n < WAIT_LIMIT);
        checkOutput("busy length", n, BUSY_CYCLES);
        checkOutput("txData held", {24'b0, txData}, 32'hA5);
        repeat (5) @(negedge clkTx);
        checkOutput("idle busy", {31'b0, busy}, 32'h0);

        // All four requesting: rotation 0,1,2,3,0 with fixed spacing.
        doReset();
        reqData = 32'h44332211;
        pushExp(0); pushExp(1); pushExp(2); pushExp(3); pushExp(0);
        applyStimulus(4'b1111);
        prevT = 0;
        for (int i = 0; i < 5; i++) begin
            waitGrant(g, w);
            t = cyc;
            if (i > 0) checkOutput("issue spacing", t - prevT, SPACING);
            prevT = t;
            if (g >= 0) begin
                req = req & ~(4'b0001 << g);
                @(negedge clkTx);
                req = req | (4'b0001 << g);
            end
        end
        applyStimulus(4'b0000);

        // Request arriving during WAIT is served right after the frame.
        waitIdle();
        reqData[15:8] = 8'h5A;
        pushExp(1);
        applyStimulus(4'b0010);
        waitGrant(g, w);
        t1 = cyc;
        applyStimulus(4'b0000);
        repeat (100) @(negedge clkTx);
        reqData[23:16] = 8'hC3;
        pushExp(2);
        applyStimulus(4'b0100);
        waitIdle();
        n = 1;
        do begin
            @(negedge clkTx);
            if (busy === 1'b0) n++;
        end while (busy === 1'b0 && n < 100);
        checkOutput("idle gap before pending grant", n, 1);
        waitGrant(g, w);
        t2 = cyc;
        checkOutput("pending grant spacing", t2 - t1, SPACING);
        applyStimulus(4'b0000);

        // Reset in the middle of a frame.
        waitIdle();
        reqData[23:16] = 8'h77;
        pushExp(2);
        applyStimulus(4'b0100);
        waitGrant(g, w);
        applyStimulus(4'b0000);
        repeat (300) @(negedge clkTx);
        #2 resetreg = 1'b1;
        #1;
        checkOutput("midframe reset busy", {31'b0, busy}, 32'h0);
        checkOutput("midframe reset txStart", {31'b0, txStart}, 32'h0);
        checkOutput("midframe reset grant", {28'b0, grant}, 32'h0);
        checkOutput("midframe reset txData", {24'b0, txData}, 32'h0);
        repeat (2) @(negedge clkTx);
        resetreg = 1'b0;
        @(negedge clkTx);
        reqData[15:8] = 8'h99;
        pushExp(1);
        applyStimulus(4'b0010);
        waitGrant(g, w);
        checkOutput("grant latency after reset", w, 2);
        applyStimulus(4'b0000);

        // One-cycle request while busy is skipped.
        repeat (50) @(negedge clkTx);
        applyStimulus(4'b1000);
        @(negedge clkTx);
        applyStimulus(4'b0000);
        waitIdle();
        n = 0;
        repeat (20) begin
            @(negedge clkTx);
            if (busy !== 1'b0) n++;
        end
        checkOutput("busy after dropped request", n, 0);

        // Requesters 0..2 held; requester 0 withdraws after the third grant.
        doReset();
        reqData = 32'h40302010;
        for (int i = 0; i < 6; i++) pushExp(seq6[i]);
        applyStimulus(4'b0111);
        for (int i = 0; i < 6; i++) begin
            waitGrant(g, w);
            if (g >= 0) begin
                req = req & ~(4'b0001 << g);
                @(negedge clkTx);
                req = req | (4'b0001 << g);
            end
            if (i == 2) req[0] = 1'b0;
        end
        applyStimulus(4'b0000);
        waitIdle();
        repeat (5) @(negedge clkTx);
        checkOutput("scoreboard drained", expQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
